fifo_rd_stream: RTL and testbench

- Reader-side companion to the team's fifo_v3 queue.
- Drains the FIFO pop interface (empty/data/pop) and presents the data as a registered valid/ready stream to IOMMU consumers, such as the CQ/FQ handlers and the PTW request path.
- A 2-entry output buffer gives full throughput while keeping fifo_pop_o free of any combinational path from ready_i.
- Also provides a saturating popped-entry counter for the formal harness and debug CSRs.

---
 rtl/fifo_rd_pkg.sv | 22 ++
 rtl/fifo_rd_stream_if.sv | 30 +++
 rtl/fifo_rd_stream.sv | 98 +++++++++
 tb/tb_fifo_rd_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types for the fifo_v3 read-side stream adapter.
// State encoding and buffer sizing used by the RTL and its interface.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_ONE   = 2'd1,
        RD_TWO   = 2'd2
    } rd_state_e;

    localparam int unsigned RD_BUF_DEPTH = 2;
    localparam int unsigned RD_LVL_W     = $clog2(RD_BUF_DEPTH + 1);

    function automatic logic [RD_LVL_W-1:0] rd_level(input rd_state_e s);
        case (s)
            RD_ONE:  return RD_LVL_W'(1);
            RD_TWO:  return RD_LVL_W'(2);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO pop port plus downstream valid/ready stream of the read adapter.
// slave = adapter side, master = FIFO/consumer side.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
);
    import fifo_rd_pkg::*;

    logic                  flush_i;
    logic                  cnt_clr_i;
    logic                  fifo_empty_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_pop_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic [RD_LVL_W-1:0]   level_o;
    logic [CNT_WIDTH-1:0]  pop_cnt_o;

    modport slave (
        input  flush_i, cnt_clr_i, fifo_empty_i, fifo_data_i, ready_i,
        output fifo_pop_o, valid_o, data_o, level_o, pop_cnt_o
    );

    modport master (
        output flush_i, cnt_clr_i, fifo_empty_i, fifo_data_i, ready_i,
        input  fifo_pop_o, valid_o, data_o, level_o, pop_cnt_o
    );

endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a fifo_v3 pop port into a registered valid/ready stream via a 2-entry head/skid buffer.
// Latency: one cycle from FIFO head to valid_o/data_o; sustains one entry per cycle.
// Backpressure: ready_i low fills the skid slot, then fifo_pop_o drops; pop never depends on ready_i.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fifo_rd_stream_if.slave     bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    rd_state_e             state_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  valid_q;
    logic [RD_LVL_W-1:0]   level_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  pop;
    logic                  out;

    // Reset gating keeps the FIFO untouched while both sides are held in reset.
    assign pop = !bus.fifo_empty_i && (state_q != RD_TWO) && !bus.flush_i && !rst_i;
    assign out = valid_q && bus.ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RD_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            level_q <= '0;
        end else if (bus.flush_i) begin
            state_q <= RD_EMPTY;
            valid_q <= 1'b0;
            level_q <= '0;
        end else begin
            case (state_q)
                RD_EMPTY: begin
                    if (pop) begin
                        state_q <= RD_ONE;
                        head_q  <= bus.fifo_data_i;
                        valid_q <= 1'b1;
                        level_q <= rd_level(RD_ONE);
                    end
                end
                RD_ONE: begin
                    if (pop && !out) begin
                        state_q <= RD_TWO;
                        skid_q  <= bus.fifo_data_i;
                        level_q <= rd_level(RD_TWO);
                    end else if (pop && out) begin
                        head_q  <= bus.fifo_data_i;
                    end else if (out) begin
                        state_q <= RD_EMPTY;
                        valid_q <= 1'b0;
                        level_q <= rd_level(RD_EMPTY);
                    end
                end
                RD_TWO: begin
                    if (out) begin
                        state_q <= RD_ONE;
                        head_q  <= skid_q;
                        level_q <= rd_level(RD_ONE);
                    end
                end
                default: begin
                    state_q <= RD_EMPTY;
                    valid_q <= 1'b0;
                    level_q <= '0;
                end
            endcase
        end
    end

    // Clear beats a same-cycle pop; the count holds at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr_i || bus.flush_i) begin
            cnt_q <= '0;
        end else if (pop && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign bus.fifo_pop_o = pop;
    assign bus.valid_o    = valid_q;
    assign bus.data_o     = head_q;
    assign bus.level_o    = level_q;
    assign bus.pop_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based source FIFO and buffer model, checked every cycle.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_i = ~clk_i;

    fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus ();
    fifo_rd_stream_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

    assign bus4.flush_i      = bus.flush_i;
    assign bus4.cnt_clr_i    = bus.cnt_clr_i;
    assign bus4.fifo_empty_i = bus.fifo_empty_i;
    assign bus4.fifo_data_i  = bus.fifo_data_i;
    assign bus4.ready_i      = bus.ready_i;

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus4.slave)
    );

    // Model: src is the upstream FIFO, mbuf the entries held by the adapter.
    logic [DW-1:0] src[$];
    logic [DW-1:0] mbuf[$];
    logic [DW-1:0] outlog[$];
    logic [DW-1:0] sent[$];
    int            cnt16, cnt4, maxlvl;
    bit            stall;
    logic [DW-1:0] stall_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_src();
        bus.fifo_empty_i = (src.size() == 0);
        bus.fifo_data_i  = (src.size() != 0) ? src[0] : 32'hDEAD_BEEF;
    endtask

    task automatic check_outputs();
        chk("valid",  64'(bus.valid_o),    64'(mbuf.size() != 0));
        chk("level",  64'(bus.level_o),    64'(mbuf.size()));
        chk("level4", 64'(bus4.level_o),   64'(mbuf.size()));
        if (mbuf.size() != 0) chk("data", 64'(bus.data_o), 64'(mbuf[0]));
        chk("cnt16",  64'(bus.pop_cnt_o),  64'(cnt16));
        chk("cnt4",   64'(bus4.pop_cnt_o), 64'(cnt4));
        if (stall) begin
            chk("hold_valid", 64'(bus.valid_o), 64'(1));
            chk("hold_data",  64'(bus.data_o),  64'(stall_dat));
        end
        if (int'(bus.level_o) > maxlvl) maxlvl = int'(bus.level_o);
    endtask

    // One clock: inputs are set by the caller just after a falling edge.
    task automatic tick();
        bit ein, eout;
        drive_src();
        #1;
        ein  = (src.size() != 0) && (mbuf.size() < 2) && !bus.flush_i;
        eout = (mbuf.size() != 0) && bus.ready_i;
        chk("fifo_pop",  64'(bus.fifo_pop_o), 64'(ein));
        chk("underflow", 64'(bus.fifo_pop_o && bus.fifo_empty_i), 64'(0));
        stall     = bus.valid_o && !bus.ready_i && !bus.flush_i;
        stall_dat = bus.data_o;
        if (bus.flush_i) begin
            if (eout) outlog.push_back(mbuf[0]);
            mbuf.delete();
        end else begin
            if (eout) outlog.push_back(mbuf.pop_front());
            if (ein)  mbuf.push_back(src.pop_front());
        end
        if (bus.cnt_clr_i || bus.flush_i) begin
            cnt16 = 0;
            cnt4  = 0;
        end else if (ein) begin
            if (cnt16 != 65535) cnt16++;
            if (cnt4 != 15)     cnt4++;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int            nxt;

        rst_i            = 1'b1;
        bus.flush_i      = 1'b0;
        bus.cnt_clr_i    = 1'b0;
        bus.ready_i      = 1'b0;
        bus.fifo_empty_i = 1'b1;
        bus.fifo_data_i  = '0;
        cnt16 = 0; cnt4 = 0; maxlvl = 0; stall = 0;

        // Reset values
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 64'(bus.valid_o),   64'(0));
        chk("rst_data",  64'(bus.data_o),    64'(0));
        chk("rst_level", 64'(bus.level_o),   64'(0));
        chk("rst_cnt",   64'(bus.pop_cnt_o), 64'(0));
        chk("rst_pop",   64'(bus.fifo_pop_o), 64'(0));

        // Basic: single entry 0xA5
        src.push_back(32'hA5);
        rst_i = 1'b0;
        drive_src();
        #1;
        chk("basic_pop", 64'(bus.fifo_pop_o), 64'(1));
        tick();
        chk("basic_valid", 64'(bus.valid_o),   64'(1));
        chk("basic_data",  64'(bus.data_o),    64'(32'hA5));
        chk("basic_level", 64'(bus.level_o),   64'(1));
        chk("basic_cnt",   64'(bus.pop_cnt_o), 64'(1));
        bus.ready_i = 1'b1;
        tick();

        // Backpressure: three entries, consumer stalled
        bus.ready_i = 1'b0;
        src.push_back(32'h1); src.push_back(32'h2); src.push_back(32'h3);
        repeat (3) tick();
        chk("bp_level", 64'(bus.level_o),   64'(2));
        chk("bp_data",  64'(bus.data_o),    64'(1));
        chk("bp_cnt",   64'(bus.pop_cnt_o), 64'(3));
        drive_src();
        #1;
        chk("bp_pop", 64'(bus.fifo_pop_o), 64'(0));
        bus.ready_i = 1'b1;
        outlog.delete();
        repeat (3) tick();
        chk("bp_outn", 64'(outlog.size()), 64'(3));
        if (outlog.size() == 3) begin
            chk("bp_out0", 64'(outlog[0]), 64'(1));
            chk("bp_out1", 64'(outlog[1]), 64'(2));
            chk("bp_out2", 64'(outlog[2]), 64'(3));
        end

        // Streaming 0..15 at full rate; narrow counter saturates
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        for (int i = 0; i < 16; i++) src.push_back(DW'(i));
        outlog.delete();
        maxlvl = 0;
        repeat (17) tick();
        chk("st_outn",   64'(outlog.size()), 64'(16));
        for (int i = 0; i < 16; i++)
            if (i < outlog.size()) chk("st_order", 64'(outlog[i]), 64'(i));
        chk("st_cnt",    64'(bus.pop_cnt_o),  64'(16));
        chk("st_maxlvl", 64'(maxlvl),         64'(1));
        chk("sat_cnt4",  64'(bus4.pop_cnt_o), 64'(4'hF));

        // Clear coinciding with a pop
        src.push_back(32'h99);
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        chk("clr_cnt4",  64'(bus4.pop_cnt_o), 64'(0));
        chk("clr_cnt16", 64'(bus.pop_cnt_o),  64'(0));
        tick();

        // Flush with two buffered entries and a handshake in the flush cycle
        bus.ready_i = 1'b0;
        src.push_back(32'h11); src.push_back(32'h22); src.push_back(32'h33);
        repeat (2) tick();
        chk("fl_level_pre", 64'(bus.level_o), 64'(2));
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b1;
        drive_src();
        #1;
        chk("fl_pop", 64'(bus.fifo_pop_o), 64'(0));
        tick();
        bus.flush_i = 1'b0;
        chk("fl_valid", 64'(bus.valid_o),   64'(0));
        chk("fl_level", 64'(bus.level_o),   64'(0));
        chk("fl_cnt",   64'(bus.pop_cnt_o), 64'(0));
        if (outlog.size() != 0) chk("fl_consumed", 64'(outlog[outlog.size()-1]), 64'(32'h11));
        repeat (2) tick();

        // Random arrivals and random ready over 100 entries
        outlog.delete();
        sent.delete();
        nxt = 0;
        for (int cyc = 0; cyc < 2000 && outlog.size() < 100; cyc++) begin
            if (nxt < 100 && $urandom_range(3) != 0) begin
                v = $urandom;
                src.push_back(v);
                sent.push_back(v);
                nxt++;
            end
            bus.ready_i = 1'($urandom_range(1));
            tick();
        end
        chk("rnd_outn", 64'(outlog.size()), 64'(100));
        for (int i = 0; i < 100; i++)
            if (i < outlog.size()) chk("rnd_order", 64'(outlog[i]), 64'(sent[i]));

        // Asynchronous reset with two entries buffered
        bus.ready_i = 1'b0;
        src.push_back(32'h5); src.push_back(32'h6);
        repeat (2) tick();
        chk("mr_level_pre", 64'(bus.level_o), 64'(2));
        #2;
        rst_i = 1'b1;
        #1;
        chk("mr_valid", 64'(bus.valid_o),    64'(0));
        chk("mr_data",  64'(bus.data_o),     64'(0));
        chk("mr_level", 64'(bus.level_o),    64'(0));
        chk("mr_cnt",   64'(bus.pop_cnt_o),  64'(0));
        chk("mr_pop",   64'(bus.fifo_pop_o), 64'(0));
        @(negedge clk_i);
        rst_i = 1'b0;
        mbuf.delete();
        cnt16 = 0; cnt4 = 0; stall = 0;

        // Recovery after reset
        src.push_back(32'h77);
        bus.ready_i = 1'b1;
        tick();
        chk("rec_valid", 64'(bus.valid_o),   64'(1));
        chk("rec_data",  64'(bus.data_o),    64'(32'h77));
        chk("rec_cnt",   64'(bus.pop_cnt_o), 64'(1));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
